// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes engine: captures one 128-bit state and substitutes LANES bytes
// per cycle in place through computed inverse S-boxes, then holds the result.
`timescale 1ns/1ps
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int unsigned GROUPS = 16 / LANES;
    localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned LSH    = $clog2(LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_data;

    logic [4:0]    w_base;
    logic [4:0]    w_idx      [LANES];
    logic [7:0]    w_lane_out [LANES];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // t^254 == t^-1 in GF(2^8); zero stays zero without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] t);
        logic [7:0] s;
        logic [7:0] r;
        s = t;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] t;
        t = {y[1:0], y[7:2]} ^ {y[4:0], y[7:5]} ^ {y[6:0], y[7]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    always_comb begin
        w_base = 5'(r_cnt) << LSH;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_idx[l]      = w_base + 5'(l);
            w_lane_out[l] = inv_sbox(r_data[{w_idx[l], 3'b000} +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (in_valid) begin
                        r_data  <= state_in;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        r_data[{w_idx[l], 3'b000} +: 8] <= w_lane_out[l];
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(GROUPS - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY) || (r_state == S_DONE);
    assign state_out = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq at LANES = 4, 1 and 16 against a
// brute-force GF(2^8) reference model.
`timescale 1ns/1ps
module tb_inv_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         iv   [3];
    logic [127:0] sin  [3];
    logic         ordy [3];
    logic         irdy [3];
    logic         ov   [3];
    logic [127:0] sout [3];
    logic         bsy  [3];

    int unsigned  grp  [3];
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [7:0]   ref_tab [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_l4 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .state_in(sin[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(sout[0]), .busy(bsy[0]));
    inv_sub_bytes_seq #(.LANES(1)) u_l1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .state_in(sin[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(sout[1]), .busy(bsy[1]));
    inv_sub_bytes_seq #(.LANES(16)) u_l16 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .state_in(sin[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(sout[2]), .busy(bsy[2]));

    // carry-less product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_isbox(input logic [7:0] y);
        logic [7:0] d;
        logic [7:0] t;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            t[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8] ^ d[i];
        if (t == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++)
            if (ref_mul(t, 8'(c)) == 8'h01) return 8'(c);
        return 8'hxx;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sends one state to instance k, checks latency, optionally holds out_ready low.
    task automatic run_block(input int k, input logic [127:0] din, input int hold,
                             output logic [127:0] dout);
        int unsigned n;
        logic [127:0] first;
        iv[k]  = 1'b1;
        sin[k] = din;
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        sin[k] = $urandom();
        n = 0;
        while (ov[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency[%0d]", k), 128'(n), 128'(grp[k]));
        dout  = sout[k];
        first = sout[k];
        for (int c = 0; c < hold; c++) begin
            if (c == 0) begin
                iv[k]  = 1'b1;
                sin[k] = ~din;
            end
            @(posedge clk); #1;
            iv[k] = 1'b0;
            chk($sformatf("hold_data[%0d]", c), sout[k], first);
            chk($sformatf("hold_ctl[%0d]", c), {125'd0, ov[k], irdy[k], bsy[k]}, {125'd0, 3'b101});
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk($sformatf("release[%0d]", k), {125'd0, ov[k], irdy[k], bsy[k]}, {125'd0, 3'b010});
    endtask

    initial begin : main
        logic [127:0] res;
        logic [127:0] din;
        logic [255:0] seen;
        logic [7:0]   spot_in  [4];
        logic [7:0]   spot_out [4];
        int unsigned  cnt;

        grp[0] = 4; grp[1] = 16; grp[2] = 1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; sin[k] = '0; ordy[k] = 1'b0;
        end
        for (int b = 0; b < 256; b++) ref_tab[b] = ref_isbox(8'(b));

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ctl[%0d]", k), {125'd0, ov[k], irdy[k], bsy[k]}, {125'd0, 3'b010});
            chk($sformatf("reset_data[%0d]", k), sout[k], '0);
        end
        reset = 1'b0;

        din = 128'h76abd7fe2b670130c56f6bf27b777c63;
        run_block(0, din, 0, res);
        chk("row0_const", res, 128'h0f0e0d0c0b0a09080706050403020100);
        chk("row0_model", res, ref_state(din));

        spot_in[0] = 8'h63; spot_out[0] = 8'h00;
        spot_in[1] = 8'h00; spot_out[1] = 8'h52;
        spot_in[2] = 8'h16; spot_out[2] = 8'hff;
        spot_in[3] = 8'hed; spot_out[3] = 8'h53;
        for (int s = 0; s < 4; s++) begin
            for (int k = 1; k < 3; k++) begin
                run_block(k, fill(spot_in[s]), 0, res);
                chk($sformatf("spot_%h[%0d]", spot_in[s], k), res, fill(spot_out[s]));
            end
        end

        din = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(0, din, 5, res);
        chk("bp_result", res, ref_state(din));
        @(posedge clk); #1;
        chk("bp_no_capture", {127'd0, bsy[0]}, 128'd0);
        chk("bp_data_kept", sout[0], ref_state(din));

        iv[0]  = 1'b1;
        sin[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ctl", {125'd0, ov[0], irdy[0], bsy[0]}, {125'd0, 3'b010});
        chk("abort_data", sout[0], '0);
        din = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(0, din, 0, res);
        chk("after_abort", res, ref_state(din));

        seen = '0;
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) din[8*i +: 8] = 8'(16 * j + i);
            run_block(j % 3, din, 0, res);
            chk($sformatf("sweep[%0d]", j), res, ref_state(din));
            for (int i = 0; i < 16; i++) seen[res[8*i +: 8]] = 1'b1;
        end
        cnt = 0;
        for (int b = 0; b < 256; b++) if (seen[b]) cnt++;
        chk("permutation", 128'(cnt), 128'd256);

        for (int r = 0; r < 6; r++) begin
            din = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block(r % 3, din, 0, res);
            chk($sformatf("random[%0d]", r), res, ref_state(din));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- AES InvSubBytes engine for the decryption datapath; the inverse of the forward S-box substitution used by encryption.
- Accepts one 128-bit state over a valid/ready handshake.
- Substitutes LANES bytes per cycle through LANES inverse S-box lookups.
- Presents the 128-bit result on a valid/ready output; sits between InvShiftRows and AddRoundKey in the decryption round loop.

Parameters:
- LANES, 4, inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
- GROUPS, 16/LANES, derived (localparam); number of BUSY cycles per block.

Ports:
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  state_in is valid
- in_ready  output  1  block can accept a state (high only in IDLE)
- state_in  input  128  ciphertext-side state; byte i = state_in[8i+7:8i]
- out_valid  output  1  state_out holds a complete substituted state
- out_ready  input  1  consumer accepts state_out
- state_out  output  128  substituted state; byte i = InvSbox(input byte i)
- busy  output  1  high in BUSY or DONE

Behaviour:
- Inverse S-box function, per byte y:
  - t = InvAffine(y): t_i = y_(i+2) ^ y_(i+5) ^ y_(i+7) ^ d_i, indices mod 8, d = 0x05.
  - Result = multiplicative inverse of t in GF(2^8) mod x^8+x^4+x^3+x+1, with 0 mapping to 0.
  - Table or computed implementation is allowed; it must be bit-exact for all 256 inputs.
- Reset (synchronous, checked at the clk edge):
  - State becomes IDLE; group counter = 0; data register = 0.
  - in_ready = 1, out_valid = 0, busy = 0, state_out = 0.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready = 1. On in_valid, capture state_in into the data register, counter = 0, go to BUSY.
  - BUSY: each cycle replace bytes counter*LANES .. counter*LANES+LANES-1 in place with their InvSbox values, then counter++. When counter == GROUPS-1 in that cycle, go to DONE.
  - DONE: out_valid = 1. state_out = data register, held stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE; out_valid falls on the next edge.
- Latency and throughput:
  - Input accepted at edge k gives out_valid high after edge k+GROUPS.
  - Minimum input-to-input spacing is GROUPS+2 cycles.
- Handshakes:
  - in_valid is ignored outside IDLE; no capture occurs and state_in is not sampled.
  - in_ready is a registered state decode with no combinational path from in_valid.
  - out_valid does not depend combinationally on out_ready.
- state_out is driven from the data register at all times; it is valid only while out_valid=1.
- Boundary conditions:
  - LANES=16 (GROUPS=1): BUSY lasts exactly 1 cycle.
  - Counter width is max(1, clog2(GROUPS)); it never wraps because it is reset in IDLE.
  - Reset asserted mid-BUSY or in DONE: abort the block, reach reset values on that edge, drop the partial result.
  - Reset has priority over every handshake event on the same edge.

Test Plan:
- Reset then idle: hold reset 2 cycles -> in_ready=1, out_valid=0, busy=0, state_out=0.
- Row-0 vector, LANES=4: state_in = 0x76abd7fe2b670130c56f6bf27b777c63 -> after 4 BUSY cycles out_valid=1, state_out = 0x0f0e0d0c0b0a09080706050403020100.
- Spot values, all 16 bytes equal: 0x63 -> all 0x00; 0x00 -> all 0x52; 0x16 -> all 0xff; 0xed -> all 0x53. Check each at LANES=1 (16 BUSY cycles) and LANES=16 (1 BUSY cycle).
- Backpressure: out_ready=0 for 5 cycles in DONE -> state_out and out_valid stable. A new in_valid pulse is ignored (in_ready=0). On out_ready=1, next cycle is IDLE with in_ready=1.
- Reset mid-BUSY: assert reset at BUSY cycle 2 of 4 -> next edge gives out_valid=0, in_ready=1. A subsequent block produces a correct result with no residue from the aborted one.
- Exhaustive sweep: feed every byte 0x00–0xff (16 per state) and compare against a reference model; the results must also be a permutation of 0x00–0xff.
